vin_source_sel: RTL and testbench

Parametrised video source selector for the board-level input path. Monitors CHANNELS already-synchronised video streams sharing one pixel clock, qualifies each by vsync activity and switches the selected stream to a single output. Switching happens only on the new source's vsync rising edge. Sits between the per-interface receivers and the colour mixer / input FIFO. It replaces the fixed two-way, valid-driven mux with counted lock qualification, an auto-priority or manual mode, and frame-aligned switching.

---
 rtl/vin_source_sel.sv | 210 +++++++++++++++++++++
 tb/tb_vin_source_sel.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vin_source_sel.sv
// vin_source_sel: qualifies CHANNELS vsync-timed video streams by counted lock
// and forwards one of them. Source changes are only ever made on the incoming
// source's vsync rising edge, so no partial frame is emitted.
module vin_source_sel #(
  parameter int CHANNELS    = 2,
  parameter int PIXEL_W     = 48,
  parameter int TIMEOUT     = 2000000,
  parameter int LOCK_FRAMES = 2,
  parameter int SELW        = $clog2(CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         in_vsync,
  input  logic [CHANNELS-1:0]         in_hsync,
  input  logic [CHANNELS-1:0]         in_de,
  input  logic [CHANNELS*PIXEL_W-1:0] in_pixel,
  input  logic                        mode,
  input  logic [SELW-1:0]             manual_sel,
  output logic                        out_vsync,
  output logic                        out_hsync,
  output logic                        out_de,
  output logic [PIXEL_W-1:0]          out_pixel,
  output logic [SELW-1:0]             out_sel,
  output logic                        out_active,
  output logic [CHANNELS-1:0]         ch_locked,
  output logic                        switch_pulse
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACTIVE  = 2'd2,
    S_PENDING = 2'd3
  } state_t;

  logic [CHANNELS-1:0] vsync_d_r;
  logic [CHANNELS-1:0] rise_s;
  logic [CW-1:0]       cnt_r       [CHANNELS];
  logic [CW-1:0]       cnt_next_s  [CHANNELS];
  logic [LW-1:0]       lock_cnt_r  [CHANNELS];
  logic [LW-1:0]       lock_next_s [CHANNELS];
  logic [CHANNELS-1:0] locked_next_s;

  state_t              state_r, state_next_s;
  logic [SELW-1:0]     cur_r, cur_next_s;
  logic                tgt_valid_s;
  logic [SELW-1:0]     tgt_s;
  logic                pass_s;
  logic [SELW-1:0]     sel_next_s;
  logic                vsync_s, hsync_s, de_s;
  logic [PIXEL_W-1:0]  pixel_s;

  assign rise_s = in_vsync & ~vsync_d_r;

  // Per-channel period counter and consecutive in-time rise counter (next values).
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_next_s[i]  = cnt_r[i];
      lock_next_s[i] = lock_cnt_r[i];
      if (rise_s[i]) begin
        cnt_next_s[i] = '0;
        if (cnt_r[i] < CNT_MAX) begin
          lock_next_s[i] = (lock_cnt_r[i] < LOCK_MAX) ? lock_cnt_r[i] + LW'(1) : lock_cnt_r[i];
        end else begin
          // a rise after a loss only restarts the period measurement
          lock_next_s[i] = '0;
        end
      end else if (cnt_r[i] < CNT_MAX) begin
        cnt_next_s[i]  = cnt_r[i] + CW'(1);
        lock_next_s[i] = ((cnt_r[i] + CW'(1)) == CNT_MAX) ? '0 : lock_cnt_r[i];
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
      locked_next_s[i] = (lock_next_s[i] == LOCK_MAX);
    end
  end

  // Per-channel monitor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= '0;
      ch_locked <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i]      <= '0;
        lock_cnt_r[i] <= '0;
      end
    end else begin
      vsync_d_r <= in_vsync;
      ch_locked <= locked_next_s;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i]      <= cnt_next_s[i];
        lock_cnt_r[i] <= lock_next_s[i];
      end
    end
  end

  // Target: lowest-index locked channel in auto mode, locked manual_sel in manual mode.
  always_comb begin
    tgt_valid_s = 1'b0;
    tgt_s       = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mode == 1'b0) begin
        tgt_valid_s = ch_locked[i] ? 1'b1 : tgt_valid_s;
        tgt_s       = ch_locked[i] ? SELW'(i) : tgt_s;
      end else begin
        tgt_valid_s = (ch_locked[i] && (manual_sel == SELW'(i))) ? 1'b1 : tgt_valid_s;
        tgt_s       = (ch_locked[i] && (manual_sel == SELW'(i))) ? SELW'(i) : tgt_s;
      end
    end
  end

  // Selection FSM next state and next passed channel.
  always_comb begin
    state_next_s = state_r;
    cur_next_s   = cur_r;
    case (state_r)
      S_IDLE: begin
        if (tgt_valid_s) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!tgt_valid_s) begin
          state_next_s = S_IDLE;
        end else if (rise_s[tgt_s]) begin
          state_next_s = S_ACTIVE;
          cur_next_s   = tgt_s;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_ACTIVE: begin
        if (!ch_locked[cur_r]) begin
          state_next_s = S_IDLE;
        end else if (tgt_valid_s && (tgt_s != cur_r)) begin
          state_next_s = S_PENDING;
        end else begin
          state_next_s = S_ACTIVE;
        end
      end
      S_PENDING: begin
        if (tgt_valid_s && (tgt_s != cur_r) && rise_s[tgt_s]) begin
          state_next_s = S_ACTIVE;
          cur_next_s   = tgt_s;
        end else if (!ch_locked[cur_r]) begin
          state_next_s = S_WAIT;
        end else if (!tgt_valid_s || (tgt_s == cur_r)) begin
          state_next_s = S_ACTIVE;
        end else begin
          state_next_s = S_PENDING;
        end
      end
      default: begin
        state_next_s = S_IDLE;
        cur_next_s   = '0;
      end
    endcase
  end

  assign pass_s     = (state_next_s == S_ACTIVE) || (state_next_s == S_PENDING);
  assign sel_next_s = pass_s ? cur_next_s : '0;

  // Stream mux for the channel chosen by the next-state logic; blank otherwise.
  always_comb begin
    vsync_s = 1'b0;
    hsync_s = 1'b0;
    de_s    = 1'b0;
    pixel_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      vsync_s = (pass_s && (cur_next_s == SELW'(i))) ? in_vsync[i] : vsync_s;
      hsync_s = (pass_s && (cur_next_s == SELW'(i))) ? in_hsync[i] : hsync_s;
      de_s    = (pass_s && (cur_next_s == SELW'(i))) ? in_de[i]    : de_s;
      pixel_s = (pass_s && (cur_next_s == SELW'(i))) ? in_pixel[i*PIXEL_W +: PIXEL_W] : pixel_s;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cur_r        <= '0;
      out_vsync    <= 1'b0;
      out_hsync    <= 1'b0;
      out_de       <= 1'b0;
      out_pixel    <= '0;
      out_sel      <= '0;
      out_active   <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cur_r        <= cur_next_s;
      out_vsync    <= vsync_s;
      out_hsync    <= hsync_s;
      out_de       <= de_s;
      out_pixel    <= pixel_s;
      out_sel      <= sel_next_s;
      out_active   <= pass_s;
      // strobe on any out_sel change and on every fresh start from blanked
      switch_pulse <= (sel_next_s != out_sel) || (pass_s && !out_active);
    end
  end

endmodule

// File: tb/tb_vin_source_sel.sv
// Scoreboard bench for vin_source_sel: random video timing per channel, a
// timestamp-based lock model and a frame-aligned selection model.
module tb_vin_source_sel;
  localparam int CH = 2;
  localparam int PW = 16;
  localparam int TO = 100;
  localparam int LF = 2;
  localparam int SW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   in_vsync = '0, in_hsync = '0, in_de = '0;
  logic [CH*PW-1:0] in_pixel = '0;
  logic            mode = 1'b0;
  logic [SW-1:0]   manual_sel = '0;
  logic            out_vsync, out_hsync, out_de, out_active, switch_pulse;
  logic [PW-1:0]   out_pixel;
  logic [SW-1:0]   out_sel;
  logic [CH-1:0]   ch_locked;

  vin_source_sel #(.CHANNELS(CH), .PIXEL_W(PW), .TIMEOUT(TO), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .in_pixel(in_pixel), .mode(mode), .manual_sel(manual_sel), .out_vsync(out_vsync),
    .out_hsync(out_hsync), .out_de(out_de), .out_pixel(out_pixel), .out_sel(out_sel),
    .out_active(out_active), .ch_locked(ch_locked), .switch_pulse(switch_pulse));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic          de;
    logic [PW-1:0] pix;
    logic [SW-1:0] sel;
    logic          act;
    logic [CH-1:0] lk;
    logic          sw;
  } obs_t;

  obs_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // vsync generators
  bit en[CH];
  int per[CH];
  int ph[CH];

  // reference model state
  bit m_prev[CH];
  int m_ref[CH];     // cycle at which "time since last rise" was zero
  int m_good[CH];
  bit m_lk[CH];
  bit m_pass, m_armed, m_pend, m_prev_act;
  int m_cur, m_prev_sel;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_prev[i] = 1'b0; m_ref[i] = cyc; m_good[i] = 0; m_lk[i] = 1'b0;
    end
    m_pass = 1'b0; m_armed = 1'b0; m_pend = 1'b0; m_prev_act = 1'b0;
    m_cur = 0; m_prev_sel = 0;
  endfunction

  function automatic obs_t model_step(input logic [CH-1:0] vs, input logic [CH-1:0] hs,
                                      input logic [CH-1:0] de, input logic [CH*PW-1:0] pix,
                                      input logic md, input logic [SW-1:0] msel);
    obs_t e;
    bit rise[CH];
    bit tv;
    int tg;
    for (int i = 0; i < CH; i++) rise[i] = vs[i] && !m_prev[i];
    tv = 1'b0; tg = 0;
    if (!md) begin
      for (int i = CH - 1; i >= 0; i--) if (m_lk[i]) begin tv = 1'b1; tg = i; end
    end else if (int'(msel) < CH && m_lk[int'(msel)]) begin
      tv = 1'b1; tg = int'(msel);
    end
    // selection: switching only ever happens on the new source's rise
    if (m_pass) begin
      if (m_pend && tv && tg != m_cur && rise[tg]) begin
        m_cur = tg; m_pend = 1'b0;
      end else if (!m_lk[m_cur]) begin
        m_pass = 1'b0; m_armed = m_pend; m_pend = 1'b0;
      end else begin
        m_pend = tv && (tg != m_cur);
      end
    end else if (m_armed) begin
      if (!tv) m_armed = 1'b0;
      else if (rise[tg]) begin m_pass = 1'b1; m_cur = tg; m_armed = 1'b0; m_pend = 1'b0; end
    end else begin
      m_armed = tv;
    end
    e = '0;
    if (m_pass) begin
      e.vs = vs[m_cur]; e.hs = hs[m_cur]; e.de = de[m_cur];
      e.pix = pix[m_cur*PW +: PW]; e.sel = SW'(m_cur); e.act = 1'b1;
    end
    e.sw = (int'(e.sel) != m_prev_sel) || (m_pass && !m_prev_act);
    m_prev_sel = int'(e.sel); m_prev_act = m_pass;
    // lock qualification from rise timestamps
    for (int i = 0; i < CH; i++) begin
      if (rise[i]) begin
        if (cyc - m_ref[i] < TO) m_good[i] = (m_good[i] < LF) ? m_good[i] + 1 : LF;
        else m_good[i] = 0;
        m_ref[i] = cyc + 1;
      end else if (cyc + 1 - m_ref[i] >= TO) begin
        m_good[i] = 0;
      end
      m_lk[i] = (m_good[i] == LF);
      e.lk[i] = m_lk[i];
      m_prev[i] = vs[i];
    end
    return e;
  endfunction

  task automatic drive_cycle();
    logic [CH-1:0] vs, hs, de;
    logic [CH*PW-1:0] pix;
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      vs[i] = en[i] && (ph[i] < 2);
      ph[i] = (ph[i] + 1) % per[i];
      hs[i] = 1'($urandom_range(0, 1));
      de[i] = 1'($urandom_range(0, 1));
      pix[i*PW +: PW] = PW'($urandom());
    end
    in_vsync = vs; in_hsync = hs; in_de = de; in_pixel = pix;
    q.push_back(model_step(vs, hs, de, pix, mode, manual_sel));
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) drive_cycle();
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_vsync, out_hsync, out_de, out_pixel, out_sel, out_active, ch_locked, switch_pulse} !== '0) begin
      fails++;
      $display("FAIL async_reset: outputs not cleared without clock, got vs=%b sel=%0d act=%b lk=%b pix=%h",
               out_vsync, out_sel, out_active, ch_locked, out_pixel);
    end
    q.delete();
    repeat (hold) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // monitor: every driven cycle produces one expected output sample
  initial begin
    obs_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {out_vsync, out_hsync, out_de, out_pixel, out_sel, out_active, ch_locked, switch_pulse};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL scoreboard t=%0t got vs=%b hs=%b de=%b pix=%h sel=%0d act=%b lk=%b sw=%b exp vs=%b hs=%b de=%b pix=%h sel=%0d act=%b lk=%b sw=%b",
                   $time, got.vs, got.hs, got.de, got.pix, got.sel, got.act, got.lk, got.sw,
                   e.vs, e.hs, e.de, e.pix, e.sel, e.act, e.lk, e.sw);
        end
      end
    end
  end

  initial begin
    int plist[7];
    plist[0] = 30; plist[1] = 50; plist[2] = 77; plist[3] = 99;
    plist[4] = 100; plist[5] = 101; plist[6] = 130;
    for (int i = 0; i < CH; i++) begin en[i] = 1'b0; per[i] = 50; ph[i] = 0; end
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    run(150);                           // idle, no vsync activity
    en[1] = 1'b1; ph[1] = 40; run(200); // ch1 locks and starts
    en[0] = 1'b1; ph[0] = 20; run(300); // ch0 takes over by priority
    en[0] = 1'b0; run(250);             // ch0 lost, fall back to ch1
    en[0] = 1'b1; ph[0] = 25; run(200);
    repeat (8) begin                    // manual selection changes mid-frame
      mode = 1'($urandom_range(0, 1));
      manual_sel = SW'($urandom_range(0, 1));
      run($urandom_range(40, 160));
    end
    mode = 1'b0; en[0] = 1'b0; run(300); // ch1 active
    async_reset(4);
    run(300);                           // relock after reset
    repeat (25) begin                   // random timing incl. periods around TIMEOUT
      for (int i = 0; i < CH; i++) begin
        en[i] = ($urandom_range(0, 5) != 0);
        per[i] = plist[$urandom_range(0, 6)];
        ph[i] = ph[i] % per[i];
      end
      mode = 1'($urandom_range(0, 1));
      manual_sel = SW'($urandom_range(0, 1));
      run($urandom_range(60, 250));
    end
    async_reset(2);
    run(100);

    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected samples left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
